// File: rtl/power_stream_buffer.sv
// power_stream_buffer
// Consumer stage for the power-of-3 generator stream. Accepted words are held
// in a first-word-fall-through FIFO and handed on through a valid/ready pair.
// While filling, the stage checks that every accepted word is three times the
// previous accepted word and counts the words offered while full.
// There is no FSM: behaviour comes from the pointers, the occupancy count,
// the expected-word register and the two status registers.

module power_stream_buffer #(
    parameter int data_size  = 32,
    parameter int depth      = 8,
    parameter int addr_width = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [data_size-1:0]  in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [data_size-1:0]  out_data,
    input  logic                  out_ready,
    output logic [addr_width:0]   count,
    output logic                  seq_error,
    output logic [15:0]           drop_count
);

    localparam logic [addr_width:0]   c_depth   = (addr_width + 1)'(depth);
    localparam logic [addr_width:0]   c_cnt_one = (addr_width + 1)'(1);
    localparam logic [addr_width-1:0] c_ptr_one = addr_width'(1);

    logic [data_size-1:0]  r_mem [depth];
    logic [addr_width-1:0] r_wr_ptr;
    logic [addr_width-1:0] r_rd_ptr;
    logic [addr_width:0]   r_count;
    logic [data_size-1:0]  r_expected;
    logic                  r_seq_error;
    logic [15:0]           r_drop_count;

    logic                  w_full;
    logic                  w_not_empty;
    logic                  w_wr;
    logic                  w_rd;
    logic                  w_drop;
    logic [data_size-1:0]  w_times3;

    assign w_full      = (r_count == c_depth);
    assign w_not_empty = (r_count != '0);
    assign w_wr        = in_valid && !w_full;
    assign w_rd        = w_not_empty && out_ready;
    assign w_drop      = in_valid && w_full;

    // x*3 as x + 2x; the carry out of the top bit is discarded (mod 2^data_size)
    assign w_times3    = in_data + {in_data[data_size-2:0], 1'b0};

    // Pointers and occupancy; the full check blocks a write even when a read
    // frees a slot on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // Sequence checker, re-seeded from the actual word so one bad word flags once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_expected  <= data_size'(1);
            r_seq_error <= 1'b0;
        end else if (w_wr) begin
            r_expected <= w_times3;
            if (in_data != r_expected) begin
                r_seq_error <= 1'b1;
            end
        end
    end

    // Saturating count of cycles where a word was offered while full
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_count <= '0;
        end else if (w_drop && (r_drop_count != 16'hFFFF)) begin
            r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign in_ready   = !w_full;
    assign out_valid  = w_not_empty;
    assign out_data   = r_mem[r_rd_ptr];
    assign count      = r_count;
    assign seq_error  = r_seq_error;
    assign drop_count = r_drop_count;

endmodule

// File: tb/tb_power_stream_buffer.sv
// Scoreboard bench for power_stream_buffer: accepted words are queued when
// driven and compared against out_data when the bench's own model says a read
// occurs; occupancy, handshake and status outputs are checked every cycle.

module tb_power_stream_buffer;

    localparam int DW = 32;
    localparam int DEPTH = 8;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic [3:0]    count;
    logic          seq_error;
    logic [15:0]   drop_count;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] m_expected;
    logic          m_seq_error;
    logic [15:0]   m_drop;
    logic [DW-1:0] pw;
    logic          acc;

    power_stream_buffer #(.data_size(DW), .depth(DEPTH), .addr_width(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .count      (count),
        .seq_error  (seq_error),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_expected  = 32'd1;
        m_seq_error = 1'b0;
        m_drop      = 16'd0;
    endtask

    // One clock: drive inputs, check pre-edge state against the model,
    // update the model for the events this edge performs, then check post-edge.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic r, output logic accepted);
        logic wr;
        logic rd;
        logic [DW-1:0] head;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        #1;
        wr = v && (q.size() < DEPTH);
        rd = r && (q.size() > 0);
        check_val("in_ready", in_ready, q.size() < DEPTH);
        check_val("out_valid", out_valid, q.size() > 0);
        if (rd) begin
            head = q.pop_front();
            check_val("rd_data", out_data, head);
        end
        if (wr) begin
            q.push_back(d);
            if (d != m_expected) m_seq_error = 1'b1;
            m_expected = d * 32'd3;
        end
        if (v && !wr && m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
        accepted = wr;
        @(posedge clk);
        #1;
        check_val("count", count, q.size());
        check_val("seq_error", seq_error, m_seq_error);
        check_val("drop_count", drop_count, m_drop);
    endtask

    // Offer the next power of three; advance only when it was accepted
    task automatic push_pow(input logic r);
        cycle(1'b1, pw, r, acc);
        if (acc) pw = pw * 32'd3;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        check_val("rst_count", count, 0);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_in_ready", in_ready, 1);
        check_val("rst_drop", drop_count, 0);
        check_val("rst_seq_error", seq_error, 0);
        #1;
        rst = 1'b0;
        model_reset();
        pw = 32'd1;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        model_reset();
        pw = 32'd1;
        #2;
        check_val("init_count", count, 0);
        check_val("init_in_ready", in_ready, 1);
        check_val("init_out_valid", out_valid, 0);
        check_val("init_drop", drop_count, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Fill with 1..2187 while the consumer stalls
        for (int i = 0; i < 8; i++) push_pow(1'b0);
        check_val("fill_count", count, 8);
        check_val("fill_in_ready", in_ready, 0);
        check_val("fill_seq_error", seq_error, 0);

        // Overflow: five offered words dropped, contents untouched
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'd6561, 1'b0, acc);
        check_val("ovf_drop", drop_count, 5);
        check_val("ovf_count", count, 8);

        // Read and offer together while full: read only, one more drop
        cycle(1'b1, 32'd6561, 1'b1, acc);
        check_val("full_rw_count", count, 7);
        check_val("full_rw_drop", drop_count, 6);

        // Drain the remaining words in order, plus one idle read request
        for (int i = 0; i < 8; i++) cycle(1'b0, 32'd0, 1'b1, acc);
        check_val("drain_out_valid", out_valid, 0);

        // Continue the sequence: fill to 4, then 10 cycles of read+write across the wrap
        for (int i = 0; i < 4; i++) push_pow(1'b0);
        for (int i = 0; i < 10; i++) push_pow(1'b1);
        check_val("rw_count", count, 4);
        check_val("rw_seq_error", seq_error, 0);

        // Reset mid-operation at count 5 with two drops recorded
        pulse_reset();
        for (int i = 0; i < 8; i++) push_pow(1'b0);
        for (int i = 0; i < 2; i++) cycle(1'b1, 32'd0, 1'b0, acc);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'd0, 1'b1, acc);
        check_val("pre_rst_count", count, 5);
        check_val("pre_rst_drop", drop_count, 2);
        pulse_reset();

        // Sequence error: 1,3,9,10,30 flags once on 10 and stays set
        cycle(1'b1, 32'd1, 1'b1, acc);
        cycle(1'b1, 32'd3, 1'b1, acc);
        cycle(1'b1, 32'd9, 1'b1, acc);
        check_val("seq_before_bad", seq_error, 0);
        cycle(1'b1, 32'd10, 1'b1, acc);
        check_val("seq_on_bad", seq_error, 1);
        cycle(1'b1, 32'd30, 1'b1, acc);
        check_val("seq_sticky", seq_error, 1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'd0, 1'b1, acc);

        // Arithmetic wrap: 3^0..3^19 then 3^20 and 3^21 mod 2^32
        pulse_reset();
        for (int i = 0; i < 20; i++) push_pow(1'b1);
        cycle(1'b1, 32'd3486784401, 1'b1, acc);
        cycle(1'b1, 32'd1870418611, 1'b1, acc);
        check_val("wrap_seq_error", seq_error, 0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'd0, 1'b1, acc);
        check_val("final_out_valid", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/power_stream_buffer.md
# power_stream_buffer

Downstream consumer stage for the `generator` power-of-3 stream. It accepts one `data_size`-bit word per cycle through a valid/ready handshake and buffers it in a `depth`-entry first-word-fall-through FIFO. The buffered words are presented to the next stage through a second valid/ready handshake. In-line, it checks that each accepted word equals three times the previous accepted word (modulo 2^`data_size`), and it counts words offered while the buffer is full.

## Interface
- `data_size`, 32, width of data words
- `depth`, 8, FIFO entries; power of two, ≥ 2
- `addr_width`, 3, log2(`depth`)
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, asynchronous, active-high
- `in_valid`  in  1  upstream word present on `in_data`
- `in_data`  in  `data_size`  upstream word (power_of_3 from `generator`)
- `in_ready`  out  1  buffer can accept; equals !full
- `out_valid`  out  1  `out_data` holds a valid head word; equals !empty
- `out_data`  out  `data_size`  FIFO head word
- `out_ready`  in  1  downstream takes head word this cycle
- `count`  out  `addr_width`+1  current occupancy, 0..`depth`
- `seq_error`  out  1  sticky flag: an accepted word broke the ×3 sequence
- `drop_count`  out  16  number of cycles with `in_valid`=1 while full; saturates at 16'hFFFF

## Operation
- Write event: `in_valid && in_ready`. The word is stored at the write pointer, and the write pointer increments (wraps modulo `depth`).
- Read event: `out_valid && out_ready`. The read pointer increments (wraps modulo `depth`).
- `count` update:
  - +1 on write only
  - −1 on read only
  - unchanged on both or neither
- Full (`count`==`depth`):
  - `in_ready`=0, so no write occurs even if a read happens in the same cycle.
  - A word offered with `in_valid`=1 is dropped, not stored, and `drop_count` increments unless it is already at 16'hFFFF.
- Empty (`count`==0): `out_valid`=0, `out_data` is don't-care, and no read occurs.
- There is no combinational bypass: a word written into an empty FIFO appears on `out_data` in the following cycle.
- Sequence checker:
  - Register `expected` resets to 1.
  - On every write event, if `in_data` != `expected`, set `seq_error`=1.
  - On every write event, load `expected` with (`in_data`×3) truncated to `data_size` bits.
  - `expected` is re-seeded from the actual word, so a single bad word flags once and does not cascade.
  - `seq_error` clears only on `rst`.
  - Dropped words are not checked and do not update `expected`.
- State machine: none beyond the pointer, count, expected and flag registers. All outputs are registered or a direct decode of `count`.

## Timing
- Reset (asynchronous, takes effect immediately):
  - pointers = 0, `count` = 0, `expected` = 1
  - `seq_error` = 0, `drop_count` = 0
  - hence `in_ready` = 1 and `out_valid` = 0 while `rst` is high and after release
- Write-to-`out_valid` latency: 1 cycle. For a word accepted at edge N into an empty FIFO, `out_valid`=1 after edge N.
- Read-to-next-word: 1 cycle. After the read at edge N, `out_data` shows the next entry (or `out_valid` drops).
- `seq_error` asserts after the edge that accepted the bad word.
- `drop_count` increments after the edge on which the drop occurred.
- Simultaneous read and write:
  - When 0<`count`<`depth`, both occur and `count` is unchanged.
  - When full, only the read occurs (count `depth`→`depth`−1).
  - When empty, only the write occurs.
- Pointer wrap is seamless; ordering is preserved across the wrap.
- `rst` asserted mid-operation discards all stored words immediately, with no drain.

## Test plan
- Fill and drain:
  - Stimulus: hold `out_ready`=0; drive 1,3,9,27,81,243,729,2187 on consecutive cycles.
  - Response: `count`=8, `in_ready`=0, `seq_error`=0.
  - Then raise `out_ready`: `out_data` reads 1..2187 in order, one per cycle, and `out_valid`=0 after the 8th read.
- Overflow:
  - Stimulus: with the FIFO full, hold `in_valid`=1 for 5 cycles with `out_ready`=0.
  - Response: `drop_count`=5, `count` stays 8, stored contents unchanged.
- Simultaneous read and write:
  - Stimulus: at `count`=4, drive `in_valid`=`out_ready`=1 for 10 cycles (pointers wrap).
  - Response: `count` stays 4 and the output order matches the input order.
  - Also at full: read+write in the same cycle gives `count`=7 and 1 drop.
- Sequence error:
  - Stimulus: accept 1,3,9,10,30.
  - Response: `seq_error`=1 after the edge accepting 10, and it stays 1.
  - No new error on 30, since `expected`=30 was re-seeded from 10.
- Arithmetic wrap:
  - Stimulus: accept 3486784401 (3^20), then 1870418611 (3^21 mod 2^32).
  - Response: `seq_error` stays 0.
- Reset mid-operation:
  - Stimulus: at `count`=5 with `drop_count`=2, pulse `rst` between clock edges.
  - Response: `count`=0, `out_valid`=0, `in_ready`=1, `drop_count`=0 immediately (before the next edge).
  - The next accepted word must be 1 to keep `seq_error`=0.
